// File: rtl/calc1_pkg.sv
// ----------------------------------------------------------------------------
// calc1_pkg
// Shared definitions for the calc1 request scheduler: command and response
// codes, port count, capture/arbiter state encodings and the command validity
// check.
// Ports: none (package).
// ----------------------------------------------------------------------------
package calc1_pkg;

    localparam int unsigned NPORTS = 4;

    localparam logic [0:3] CMD_ADD = 4'd1;
    localparam logic [0:3] CMD_SUB = 4'd2;
    localparam logic [0:3] CMD_SHL = 4'd5;
    localparam logic [0:3] CMD_SHR = 4'd6;

    localparam logic [0:1] RESP_NONE    = 2'd0;
    localparam logic [0:1] RESP_OK      = 2'd1;
    localparam logic [0:1] RESP_ERR     = 2'd2;
    localparam logic [0:1] RESP_TIMEOUT = 2'd3;

    typedef enum logic [1:0] {
        ArbIdle,
        ArbIssue,
        ArbWait,
        ArbResp
    } arb_state_e;

    typedef enum logic [1:0] {
        CapIdle,
        CapOp2,
        CapPend
    } cap_state_e;

    function automatic logic is_valid_cmd(input logic [0:3] cmd);
        return (cmd == CMD_ADD) || (cmd == CMD_SUB) || (cmd == CMD_SHL) || (cmd == CMD_SHR);
    endfunction

endpackage

// File: rtl/calc1_req_scheduler_if.sv
// ----------------------------------------------------------------------------
// calc1_req_scheduler_if
// Bundles the four requester ports and the shared ALU handshake.
//   req_cmd/req_data   : requester command / operand inputs (per port)
//   out_resp/out_data  : per-port one-cycle response
//   alu_valid/cmd/op1/op2 : issue strobe and operands toward the ALU
//   alu_done/resp/data : completion strobe and result from the ALU
// Modports: slave = scheduler side, master = requesters + ALU side.
// ----------------------------------------------------------------------------
interface calc1_req_scheduler_if;
    import calc1_pkg::*;

    logic [0:3]  req_cmd  [NPORTS];
    logic [0:31] req_data [NPORTS];
    logic [0:1]  out_resp [NPORTS];
    logic [0:31] out_data [NPORTS];

    logic        alu_valid;
    logic [0:3]  alu_cmd;
    logic [0:31] alu_op1;
    logic [0:31] alu_op2;
    logic        alu_done;
    logic [0:1]  alu_resp;
    logic [0:31] alu_data;

    modport slave (
        input  req_cmd, req_data, alu_done, alu_resp, alu_data,
        output out_resp, out_data, alu_valid, alu_cmd, alu_op1, alu_op2
    );

    modport master (
        output req_cmd, req_data, alu_done, alu_resp, alu_data,
        input  out_resp, out_data, alu_valid, alu_cmd, alu_op1, alu_op2
    );

endinterface

// File: rtl/calc1_port_capture.sv
// ----------------------------------------------------------------------------
// calc1_port_capture
// Captures one requester's two-cycle request (cmd + op1, then op2) and holds
// it as pending until the arbiter releases the port after its response.
//   c_clk, reset : clock, asynchronous active-high reset
//   i_cmd/i_data : requester command and data
//   i_release    : one-cycle release from the arbiter (response driven)
//   o_pend       : request held and waiting for / under service
//   o_cmd/o_op1/o_op2 : held request
// ----------------------------------------------------------------------------
module calc1_port_capture
    import calc1_pkg::*;
(
    input  logic        c_clk,
    input  logic        reset,
    input  logic [0:3]  i_cmd,
    input  logic [0:31] i_data,
    input  logic        i_release,
    output logic        o_pend,
    output logic [0:3]  o_cmd,
    output logic [0:31] o_op1,
    output logic [0:31] o_op2
);

    cap_state_e  r_state;
    cap_state_e  w_state_nxt;
    logic        w_take_op1;
    logic        w_take_op2;
    logic [0:3]  r_cmd;
    logic [0:31] r_op1;
    logic [0:31] r_op2;

    always_comb begin
        w_state_nxt = r_state;
        w_take_op1  = 1'b0;
        w_take_op2  = 1'b0;
        unique case (r_state)
            CapIdle: begin
                if (i_cmd != '0) begin
                    w_take_op1  = 1'b1;
                    w_state_nxt = CapOp2;
                end
            end
            // Second beat is always op2; any cmd seen here is dropped.
            CapOp2: begin
                w_take_op2  = 1'b1;
                w_state_nxt = CapPend;
            end
            CapPend: begin
                if (i_release) begin
                    w_state_nxt = CapIdle;
                end
            end
            default: w_state_nxt = CapIdle;
        endcase
    end

    always_ff @(posedge c_clk or posedge reset) begin
        if (reset) begin
            r_state <= CapIdle;
            r_cmd   <= '0;
            r_op1   <= '0;
            r_op2   <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (w_take_op1) begin
                r_cmd <= i_cmd;
                r_op1 <= i_data;
            end
            if (w_take_op2) begin
                r_op2 <= i_data;
            end
        end
    end

    assign o_pend = (r_state == CapPend);
    assign o_cmd  = r_cmd;
    assign o_op1  = r_op1;
    assign o_op2  = r_op2;

endmodule

// File: rtl/calc1_req_scheduler.sv
// ----------------------------------------------------------------------------
// calc1_req_scheduler
// Shares one ALU among four requester ports: round-robin grant among pending
// ports, single outstanding ALU operation, invalid-command and timeout
// responses generated locally, result routed back to the granted port.
//   c_clk, reset : clock, asynchronous active-high reset
//   bus          : calc1_req_scheduler_if.slave (requesters + ALU)
//   TIMEOUT      : cycles waited for alu_done after issue (>= 2)
// ----------------------------------------------------------------------------
module calc1_req_scheduler
    import calc1_pkg::*;
#(
    parameter int unsigned TIMEOUT = 16
) (
    input  logic                  c_clk,
    input  logic                  reset,
    calc1_req_scheduler_if.slave  bus
);

    localparam int unsigned CntW = $clog2(TIMEOUT);

    arb_state_e        r_state;
    arb_state_e        w_state_nxt;
    logic [1:0]        r_rr;
    logic [1:0]        w_rr_nxt;
    logic [1:0]        r_gnt;
    logic [1:0]        w_gnt_nxt;
    logic [CntW-1:0]   r_cnt;
    logic [CntW-1:0]   w_cnt_nxt;
    logic [0:1]        r_resp;
    logic [0:1]        w_resp_nxt;
    logic [0:31]       r_data;
    logic [0:31]       w_data_nxt;

    logic [NPORTS-1:0] w_pend;
    logic [NPORTS-1:0] w_release;
    logic [0:3]        w_cmd [NPORTS];
    logic [0:31]       w_op1 [NPORTS];
    logic [0:31]       w_op2 [NPORTS];

    logic              w_found;
    logic [1:0]        w_pick;
    logic [1:0]        w_idx;
    logic              w_alu_valid;

    for (genvar p = 0; p < NPORTS; p++) begin : g_port
        calc1_port_capture u_cap (
            .c_clk     (c_clk),
            .reset     (reset),
            .i_cmd     (bus.req_cmd[p]),
            .i_data    (bus.req_data[p]),
            .i_release (w_release[p]),
            .o_pend    (w_pend[p]),
            .o_cmd     (w_cmd[p]),
            .o_op1     (w_op1[p]),
            .o_op2     (w_op2[p])
        );

        assign bus.out_resp[p] = (r_state == ArbResp && r_gnt == 2'(p)) ? r_resp : RESP_NONE;
        assign bus.out_data[p] = (r_state == ArbResp && r_gnt == 2'(p)) ? r_data : '0;
    end

    // First pending port at or after r_rr; 2-bit index wraps 3 -> 0.
    always_comb begin
        w_found = 1'b0;
        w_pick  = r_rr;
        w_idx   = r_rr;
        for (int i = 0; i < NPORTS; i++) begin
            w_idx = r_rr + 2'(i);
            if (!w_found && w_pend[w_idx]) begin
                w_found = 1'b1;
                w_pick  = w_idx;
            end
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_rr_nxt    = r_rr;
        w_gnt_nxt   = r_gnt;
        w_cnt_nxt   = r_cnt;
        w_resp_nxt  = r_resp;
        w_data_nxt  = r_data;
        w_release   = '0;
        w_alu_valid = 1'b0;
        unique case (r_state)
            ArbIdle: begin
                if (w_found) begin
                    w_gnt_nxt   = w_pick;
                    w_state_nxt = ArbIssue;
                end
            end
            ArbIssue: begin
                if (is_valid_cmd(w_cmd[r_gnt])) begin
                    w_alu_valid = 1'b1;
                    w_cnt_nxt   = '0;
                    w_state_nxt = ArbWait;
                end else begin
                    w_resp_nxt  = RESP_ERR;
                    w_data_nxt  = '0;
                    w_state_nxt = ArbResp;
                end
            end
            // Counter value k means this is the (k+1)-th WAIT cycle; a done in
            // the last one still wins over the timeout.
            ArbWait: begin
                if (bus.alu_done) begin
                    w_resp_nxt  = bus.alu_resp;
                    w_data_nxt  = (bus.alu_resp == RESP_OK) ? bus.alu_data : '0;
                    w_state_nxt = ArbResp;
                end else if (r_cnt == CntW'(TIMEOUT - 1)) begin
                    w_resp_nxt  = RESP_TIMEOUT;
                    w_data_nxt  = '0;
                    w_state_nxt = ArbResp;
                end else begin
                    w_cnt_nxt = r_cnt + CntW'(1);
                end
            end
            ArbResp: begin
                w_release[r_gnt] = 1'b1;
                w_rr_nxt         = r_gnt + 2'd1;
                w_state_nxt      = ArbIdle;
            end
            default: w_state_nxt = ArbIdle;
        endcase
    end

    always_ff @(posedge c_clk or posedge reset) begin
        if (reset) begin
            r_state <= ArbIdle;
            r_rr    <= '0;
            r_gnt   <= '0;
            r_cnt   <= '0;
            r_resp  <= RESP_NONE;
            r_data  <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_rr    <= w_rr_nxt;
            r_gnt   <= w_gnt_nxt;
            r_cnt   <= w_cnt_nxt;
            r_resp  <= w_resp_nxt;
            r_data  <= w_data_nxt;
        end
    end

    assign bus.alu_valid = w_alu_valid;
    assign bus.alu_cmd   = w_alu_valid ? w_cmd[r_gnt] : '0;
    assign bus.alu_op1   = w_alu_valid ? w_op1[r_gnt] : '0;
    assign bus.alu_op2   = w_alu_valid ? w_op2[r_gnt] : '0;

endmodule

// File: tb/tb_calc1_req_scheduler.sv
// ----------------------------------------------------------------------------
// tb_calc1_req_scheduler
// Self-checking bench: an event-time model predicts every cycle's outputs,
// a simple ALU stub answers issues, and directed scenarios pin exact cycles.
// ----------------------------------------------------------------------------
module tb_calc1_req_scheduler;
    import calc1_pkg::*;

    localparam int TO = 16;

    logic c_clk = 1'b0;
    logic reset = 1'b1;
    always #5 c_clk = ~c_clk;

    calc1_req_scheduler_if bus ();

    calc1_req_scheduler #(.TIMEOUT(TO)) dut (
        .c_clk (c_clk),
        .reset (reset),
        .bus   (bus)
    );

    int cyc = 0;
    int n_pass = 0;
    int n_total = 0;

    function automatic void chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_total++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, got, exp, cyc);
    endfunction

    // ------------------------------------------------------------ ALU stub
    int          stub_lat = 1;    // 0 = never answers
    bit          stub_err = 1'b0;
    int          stub_due = -1;
    int          inject_cyc = -1; // stray done pulse cycle
    logic [0:31] stub_res = '0;

    function automatic logic [0:31] alu_fn(input logic [0:3] c, input logic [0:31] a,
                                           input logic [0:31] b);
        case (c)
            4'd1:    return a + b;
            4'd2:    return a - b;
            4'd5:    return a << b[27:31];
            4'd6:    return a >> b[27:31];
            default: return '0;
        endcase
    endfunction

    always @(negedge c_clk) begin
        if (reset !== 1'b1 && bus.alu_valid === 1'b1) begin
            stub_due = (stub_lat > 0) ? cyc + stub_lat : -1;
            stub_res = alu_fn(bus.alu_cmd, bus.alu_op1, bus.alu_op2);
        end
    end

    always @(posedge c_clk) begin
        #1;
        bus.alu_done = (cyc == stub_due) || (cyc == inject_cyc);
        bus.alu_resp = stub_err ? RESP_ERR : RESP_OK;
        bus.alu_data = stub_err ? 32'hDEAD_BEEF : stub_res;
    end

    // ------------------------------------------------------------ model
    // Tracks each port as idle / awaiting op2 / queued and the scheduler as
    // timestamps: when the next op is issued, when its response appears.
    int          m_st [4];
    logic [0:3]  m_cmd [4];
    logic [0:31] m_op1 [4];
    logic [0:31] m_op2 [4];
    int          m_elig [4];
    int          m_rr = 0, m_gnt = -1, m_issue = -1, m_free = 0, m_p;
    bit          m_wait = 1'b0;

    int          exp_issue_cyc = -1, exp_resp_cyc = -1, exp_resp_port = -1;
    logic [0:3]  exp_cmd;
    logic [0:31] exp_op1, exp_op2, exp_data;
    logic [0:1]  exp_resp;

    function automatic bit valid_cmd(input logic [0:3] c);
        return c == 4'd1 || c == 4'd2 || c == 4'd5 || c == 4'd6;
    endfunction

    always @(posedge c_clk) begin
        if (reset === 1'b1) begin
            for (int p = 0; p < 4; p++) m_st[p] = 0;
            m_rr = 0; m_gnt = -1; m_issue = -1; m_free = 0; m_wait = 1'b0;
            exp_issue_cyc = -1; exp_resp_cyc = -1; exp_resp_port = -1;
        end else begin
            for (int p = 0; p < 4; p++) begin
                if (m_st[p] == 0 && bus.req_cmd[p] != 4'd0) begin
                    m_cmd[p] = bus.req_cmd[p]; m_op1[p] = bus.req_data[p]; m_st[p] = 1;
                end else if (m_st[p] == 1) begin
                    m_op2[p] = bus.req_data[p]; m_st[p] = 2; m_elig[p] = cyc + 1;
                end
            end
            if (m_gnt >= 0 && m_wait) begin
                if (cyc > m_issue && cyc <= m_issue + TO && bus.alu_done === 1'b1) begin
                    m_wait = 1'b0; exp_resp_cyc = cyc + 1; exp_resp_port = m_gnt;
                    exp_resp = bus.alu_resp;
                    exp_data = (bus.alu_resp == 2'd1) ? bus.alu_data : 32'd0;
                end else if (cyc == m_issue + TO) begin
                    m_wait = 1'b0; exp_resp_cyc = cyc + 1; exp_resp_port = m_gnt;
                    exp_resp = 2'd3; exp_data = '0;
                end
            end
            if (m_gnt >= 0 && cyc == exp_resp_cyc) begin
                m_st[m_gnt] = 0; m_rr = (m_gnt + 1) % 4; m_gnt = -1; m_free = cyc + 1;
            end else if (m_gnt < 0 && cyc >= m_free) begin
                for (int k = 0; k < 4; k++) begin
                    m_p = (m_rr + k) % 4;
                    if (m_gnt < 0 && m_st[m_p] == 2 && m_elig[m_p] <= cyc) m_gnt = m_p;
                end
                if (m_gnt >= 0) begin
                    if (valid_cmd(m_cmd[m_gnt])) begin
                        m_issue = cyc + 1; m_wait = 1'b1; exp_issue_cyc = cyc + 1;
                        exp_cmd = m_cmd[m_gnt]; exp_op1 = m_op1[m_gnt]; exp_op2 = m_op2[m_gnt];
                    end else begin
                        exp_resp_cyc = cyc + 2; exp_resp_port = m_gnt;
                        exp_resp = 2'd2; exp_data = '0;
                    end
                end
            end
        end
        cyc++;
    end

    // ------------------------------------------------------------ compare
    int          iss_op1_q [$];
    int          iss_cyc_q [$];
    int          rs_cyc_q [$];
    int          rs_port_q [$];
    int          rs_val_q [$];
    logic [0:31] rs_data_q [$];
    bit          ev;

    always @(negedge c_clk) begin
        if (cyc > 0) begin
            if (reset === 1'b1) begin
                chk("rst_alu_valid", 64'(bus.alu_valid), 64'd0);
                for (int p = 0; p < 4; p++) begin
                    chk($sformatf("rst_out_resp%0d", p + 1), 64'(bus.out_resp[p]), 64'd0);
                    chk($sformatf("rst_out_data%0d", p + 1), 64'(bus.out_data[p]), 64'd0);
                end
            end else begin
                ev = (cyc == exp_issue_cyc);
                chk("alu_valid", 64'(bus.alu_valid), 64'(ev));
                if (ev) begin
                    chk("alu_cmd", 64'(bus.alu_cmd), 64'(exp_cmd));
                    chk("alu_op1", 64'(bus.alu_op1), 64'(exp_op1));
                    chk("alu_op2", 64'(bus.alu_op2), 64'(exp_op2));
                end
                if (bus.alu_valid === 1'b1) begin
                    iss_op1_q.push_back(int'(bus.alu_op1)); iss_cyc_q.push_back(cyc);
                end
                for (int p = 0; p < 4; p++) begin
                    ev = (cyc == exp_resp_cyc && p == exp_resp_port);
                    chk($sformatf("out_resp%0d", p + 1), 64'(bus.out_resp[p]),
                        ev ? 64'(exp_resp) : 64'd0);
                    chk($sformatf("out_data%0d", p + 1), 64'(bus.out_data[p]),
                        ev ? 64'(exp_data) : 64'd0);
                    if (bus.out_resp[p] != 2'd0) begin
                        rs_cyc_q.push_back(cyc); rs_port_q.push_back(p);
                        rs_val_q.push_back(int'(bus.out_resp[p])); rs_data_q.push_back(bus.out_data[p]);
                    end
                end
            end
        end
    end

    // ------------------------------------------------------------ stimulus
    task automatic step(input int n = 1);
        repeat (n) begin
            @(posedge c_clk);
            #1;
        end
    endtask

    task automatic clear_logs();
        iss_op1_q.delete(); iss_cyc_q.delete();
        rs_cyc_q.delete(); rs_port_q.delete(); rs_val_q.delete(); rs_data_q.delete();
    endtask

    task automatic req(input int p, input logic [0:3] cmd, input logic [0:31] a,
                       input logic [0:31] b);
        bus.req_cmd[p] = cmd; bus.req_data[p] = a;
        step();
        bus.req_cmd[p] = '0; bus.req_data[p] = b;
        step();
        bus.req_data[p] = '0;
    endtask

    task automatic expect_one_resp(input string name, input int p, input int at,
                                   input int val, input logic [0:31] data);
        chk({name, "_count"}, 64'(rs_cyc_q.size()), 64'd1);
        if (rs_cyc_q.size() >= 1) begin
            chk({name, "_port"}, 64'(rs_port_q[0]), 64'(p));
            chk({name, "_cycle"}, 64'(rs_cyc_q[0]), 64'(at));
            chk({name, "_resp"}, 64'(rs_val_q[0]), 64'(val));
            chk({name, "_data"}, 64'(rs_data_q[0]), 64'(data));
        end
    endtask

    int n0;

    initial begin
        for (int p = 0; p < 4; p++) begin
            bus.req_cmd[p] = '0; bus.req_data[p] = '0;
        end
        step(3);
        #1;
        chk("reset_alu_valid", 64'(bus.alu_valid), 64'd0);
        chk("reset_out_resp1", 64'(bus.out_resp[0]), 64'd0);
        reset = 1'b0;
        step(2);

        // All four ports at once: order follows rr from port 1.
        clear_logs();
        fork
            req(0, CMD_ADD, 32'd10, 32'd0);
            req(1, CMD_ADD, 32'd11, 32'd1);
            req(2, CMD_ADD, 32'd12, 32'd2);
            req(3, CMD_ADD, 32'd13, 32'd3);
        join
        step(30);
        chk("rr4_count", 64'(iss_op1_q.size()), 64'd4);
        for (int i = 0; i < 4; i++)
            if (iss_op1_q.size() > i)
                chk($sformatf("rr4_order%0d", i), 64'(iss_op1_q[i]), 64'(10 + i));
        chk("rr4_resp_count", 64'(rs_cyc_q.size()), 64'd4);

        // Port 2 served last, then ports 3 and 1 together -> 3 first.
        req(1, CMD_ADD, 32'd21, 32'd1);
        step(8);
        clear_logs();
        fork
            req(2, CMD_ADD, 32'd32, 32'd0);
            req(0, CMD_ADD, 32'd30, 32'd0);
        join
        step(15);
        chk("rr2_count", 64'(iss_op1_q.size()), 64'd2);
        if (iss_op1_q.size() == 2) begin
            chk("rr2_first", 64'(iss_op1_q[0]), 64'd32);
            chk("rr2_second", 64'(iss_op1_q[1]), 64'd30);
        end

        // Minimum-latency add on port 1.
        clear_logs();
        n0 = cyc;
        req(0, CMD_ADD, 32'd1, 32'h01FF_FFFF);
        step(6);
        chk("add_issue_cycle", 64'(iss_cyc_q.size() > 0 ? iss_cyc_q[0] : -1), 64'(n0 + 3));
        expect_one_resp("add", 0, n0 + 5, 1, 32'h0200_0000);

        // Invalid command on port 2.
        clear_logs();
        n0 = cyc;
        req(1, 4'd3, 32'd7, 32'd8);
        step(6);
        chk("inv_no_issue", 64'(iss_op1_q.size()), 64'd0);
        expect_one_resp("inv", 1, n0 + 4, 2, 32'd0);

        // Timeout, then a stray done while idle, then a normal request.
        clear_logs();
        stub_lat = 0;
        n0 = cyc;
        req(0, CMD_ADD, 32'd5, 32'd6);
        step(TO + 6);
        chk("to_issue_cycle", 64'(iss_cyc_q.size() > 0 ? iss_cyc_q[0] : -1), 64'(n0 + 3));
        expect_one_resp("to", 0, n0 + 3 + TO + 1, 3, 32'd0);
        inject_cyc = cyc + 2;
        step(6);
        chk("late_done_ignored", 64'(rs_cyc_q.size()), 64'd1);
        clear_logs();
        stub_lat = 1;
        n0 = cyc;
        req(0, CMD_SUB, 32'd9, 32'd4);
        step(6);
        expect_one_resp("after_to", 0, n0 + 5, 1, 32'd5);

        // ALU reports underflow with garbage data.
        clear_logs();
        stub_err = 1'b1;
        n0 = cyc;
        req(2, CMD_SUB, 32'd1, 32'd15);
        step(6);
        expect_one_resp("uflow", 2, n0 + 5, 2, 32'd0);
        stub_err = 1'b0;

        // Reset while waiting on the ALU with other ports pending.
        stub_lat = 0;
        fork
            req(0, CMD_ADD, 32'd1, 32'd1);
            req(1, CMD_ADD, 32'd2, 32'd2);
            req(3, CMD_SHL, 32'd3, 32'd3);
        join
        step(4);
        reset = 1'b1;
        #1;
        chk("midrst_alu_valid", 64'(bus.alu_valid), 64'd0);
        chk("midrst_out_resp1", 64'(bus.out_resp[0]), 64'd0);
        step(2);
        reset = 1'b0;
        stub_lat = 1;
        clear_logs();
        step(30);
        chk("midrst_no_issue", 64'(iss_op1_q.size()), 64'd0);
        chk("midrst_no_resp", 64'(rs_cyc_q.size()), 64'd0);
        n0 = cyc;
        req(1, CMD_ADD, 32'd100, 32'd23);
        step(6);
        expect_one_resp("fresh", 1, n0 + 5, 1, 32'd123);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1);
    end

endmodule

// File: doc/calc1_req_scheduler.md
# calc1_req_scheduler

Front-end scheduler that shares one calculator ALU among four requester ports of the calc1 design. It captures each port's two-cycle request (command + operand 1, then operand 2), arbitrates round-robin among pending ports, and issues one operation at a time to the ALU. It then routes the ALU result back to the originating port as a one-cycle response, and generates invalid-command and timeout responses itself.

## Interface
- TIMEOUT, 16, max cycles waited for alu_done after issue before a timeout response (≥2)
- NPORTS, 4, requester ports (fixed 4 in this release)
- c_clk  in  1  clock, all logic rising-edge
- reset  in  1  asynchronous, active-high; clears all state
- reqN_cmd_in  in  [0:3]  command, N=1..4; 0 = idle, nonzero = start of request
- reqN_data_in  in  [0:31]  operand 1 in cmd cycle, operand 2 in following cycle
- out_respN  out  [0:1]  0 none, 1 success, 2 overflow/underflow/invalid cmd, 3 timeout
- out_dataN  out  [0:31]  result; valid only while out_respN==1, else 0
- alu_valid  out  1  one-cycle issue strobe
- alu_cmd  out  [0:3]  command to ALU
- alu_op1, alu_op2  out  [0:31]  operands
- alu_done  in  1  one-cycle completion strobe, ≥1 cycle after alu_valid
- alu_resp  in  [0:1]  1 success, 2 overflow/underflow
- alu_data  in  [0:31]  result, sampled with alu_done

## Operation
- Valid commands: 1 add, 2 subtract, 5 shift left, 6 shift right. All other nonzero values are invalid.
- Per-port capture FSM, states IDLE → OP2 → PEND:
  - IDLE: nonzero cmd is sampled → store cmd and op1, go to OP2.
  - OP2: next cycle's data is stored as op2 unconditionally; cmd in this cycle is ignored. Go to PEND.
  - PEND: wait for grant; cmd on this port is ignored (dropped, no response) until its response has been driven.
- Arbiter FSM, states IDLE / ISSUE / WAIT / RESP:
  - IDLE: if any port is PEND, grant the first PEND port at or after rr_ptr (order 1→2→3→4→1), then go to ISSUE.
  - ISSUE, valid cmd: drive alu_valid=1 with held cmd/op1/op2 for exactly one cycle, go to WAIT, timeout counter = 0.
  - ISSUE, invalid cmd: no ALU issue; load resp 2, data 0; go to RESP.
  - WAIT: alu_done → latch alu_resp/alu_data, go to RESP. Otherwise increment the counter; at TIMEOUT, load resp 3, data 0, go to RESP.
  - RESP: drive the granted port's out_resp/out_data for exactly one cycle. Release that port to IDLE, set rr_ptr = granted+1 (mod 4), return to IDLE.
- If alu_resp≠1, out_data is forced to 0.
- alu_done outside WAIT is ignored, including a late done after a timeout.
- Non-granted ports hold out_resp=0 and out_data=0 at all times.

## Timing
- Reset: all outputs 0; all FSMs IDLE; rr_ptr = port 1; counters 0. Asserting reset mid-operation aborts everything; pending requests are lost and no response is produced.
- Request with cmd in cycle N, ALU done in cycle M → out_resp in cycle M+1. Minimum path: capture completes end of N+1, grant in N+2, alu_valid in N+3, earliest done N+4, response N+5.
- Invalid command: response in N+4.
- Timeout: response TIMEOUT+1 cycles after the alu_valid cycle.
- Back-to-back operations: the next grant is evaluated in the IDLE cycle following RESP, so at most one ALU operation is in flight.
- Simultaneous PEND on several ports: round-robin order only; no starvation, worst-case wait is 3 full operations.
- A port may start a new request in the cycle after its response.

## Structure
- Shared package calc1_pkg:
  - command constants CMD_ADD=1, CMD_SUB=2, CMD_SHL=5, CMD_SHR=6
  - response constants RESP_NONE/OK/ERR/TIMEOUT
  - arbiter state enum
  - function is_valid_cmd
- Sub-module calc1_port_capture, instantiated 4×: capture FSM plus held cmd/op1/op2, pending flag and release input.
- Top level holds the arbiter FSM, rr_ptr, timeout counter and response mux.

## Test plan
- Port 1 add, op1=1, op2=32'h1FF_FFFF; ALU model returns (1, 32'h200_0000) 1 cycle after issue → out_resp1=1, out_data1=32'h200_0000 exactly in cycle N+5, one cycle only.
- Ports 1–4 all issue add in the same cycle → alu_valid order 1,2,3,4; then ports 3 and 1 together after port 2 last served → order 3,1.
- Port 2 cmd=3 → out_resp2=2, out_data2=0 at N+4; alu_valid never asserted.
- ALU model never asserts done, TIMEOUT=16 → out_resp1=3 at issue+17; later alu_done ignored; next request is served normally.
- ALU returns resp 2 with data 32'hDEAD_BEEF for subtract 1−15 → out_resp=2, out_data=0.
- Reset asserted while in WAIT with 2 ports pending → all outputs 0 immediately; no responses after reset release; a fresh request completes normally.
